// File: rtl/log_unit_pkg.sv
// Shared definitions for the parametrised float32 logarithm unit:
// FSM states, base-select codes, scaling constants and float encodings.
package log_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ITER,
        ST_SCALE,
        ST_NORM,
        ST_DONE
    } state_t;

    localparam logic [1:0] MODE_LOG2  = 2'b00;
    localparam logic [1:0] MODE_LN    = 2'b01;
    localparam logic [1:0] MODE_LOG10 = 2'b10;
    localparam logic [1:0] MODE_RSVD  = 2'b11;

    // Base-change constants ln(2) and log10(2), unsigned Q0.32
    localparam logic [31:0] K_LN2     = 32'hB17217F8;
    localparam logic [31:0] K_LOG10_2 = 32'h4D104D42;

    localparam logic [31:0] QNAN    = 32'h7FC00000;
    localparam logic [31:0] NEG_INF = 32'hFF800000;
    localparam logic [31:0] POS_INF = 32'h7F800000;

    localparam int EXP_BIAS = 127;

    typedef struct packed {
        logic        special;
        logic        err;
        logic [31:0] q;
    } class_t;

    // Special-operand classification; reserved mode outranks every operand check
    function automatic class_t classify(input logic [1:0] mode, input logic [31:0] x);
        class_t c;
        c.special = 1'b1;
        c.err     = 1'b1;
        c.q       = QNAN;
        if (mode == MODE_RSVD) begin
            c.q = QNAN;
        end else if (x[30:23] == 8'hFF && x[22:0] != 23'd0) begin
            c.q = QNAN;
        end else if (x[31] && x[30:0] != 31'd0) begin
            c.q = QNAN;
        end else if (x[30:23] == 8'h00) begin
            c.q = NEG_INF;
        end else if (x[30:23] == 8'hFF) begin
            c.q   = POS_INF;
            c.err = 1'b0;
        end else begin
            c.special = 1'b0;
            c.err     = 1'b0;
            c.q       = 32'h0;
        end
        return c;
    endfunction

endpackage

// File: rtl/log_fix_to_fp.sv
// Combinational signed Q8.ITER to float32 converter: magnitude, leading-one
// detect, normalising shift, mantissa truncated to 23 bits. Zero maps to +0.
module log_fix_to_fp
    import log_unit_pkg::*;
#(
    parameter int ITER = 24
) (
    input  logic signed [ITER+7:0] fix_i,
    output logic        [31:0]     fp_o
);

    localparam int W  = ITER + 8;
    localparam int PW = $clog2(W);

    logic signed [W-1:0]  neg_d;
    logic        [W-1:0]  mag_d;
    logic        [PW-1:0] pos_d;
    logic                 nz_d;
    logic        [W+22:0] wide_d;
    logic        [22:0]   mant_d;
    logic        [7:0]    expo_d;

    // Magnitude, leading-one position and normalised mantissa/exponent
    always_comb begin
        neg_d = -fix_i;
        mag_d = fix_i[W-1] ? $unsigned(neg_d) : $unsigned(fix_i);
        pos_d = '0;
        nz_d  = 1'b0;
        for (int i = 0; i < W; i++) begin
            if (mag_d[i]) begin
                pos_d = PW'(i);
                nz_d  = 1'b1;
            end
        end
        // Leading one lands in the top bit; the 23 bits under it are the mantissa
        wide_d = {mag_d, 23'b0} << (W - 1 - int'(pos_d));
        mant_d = 23'(wide_d >> (W - 1));
        expo_d = 8'(EXP_BIAS - ITER + int'(pos_d));
        fp_o   = nz_d ? {fix_i[W-1], expo_d, mant_d} : 32'h0;
    end

endmodule

// File: rtl/log_unit_param.sv
// Multi-cycle float32 logarithm (log2 / ln / log10). log2 of the mantissa is
// produced one fraction bit per cycle by repeated squaring, joined with the
// unbiased exponent, scaled to the requested base and converted back to float.
module log_unit_param
    import log_unit_pkg::*;
#(
    parameter int ITER = 24,
    parameter int YW   = 32
) (
    input  logic        clk_95,
    input  logic        reset_95,
    input  logic        Enable_95,
    input  logic [1:0]  Mode_95,
    input  logic [31:0] Op_X_95,
    output logic [31:0] Op_Q_95,
    output logic        Error_95,
    output logic        Done_95,
    output logic        Busy_95
);

    localparam int LW = ITER + 8;
    localparam int CW = $clog2(ITER);

    state_t                state_q;
    logic        [1:0]     mode_q;
    logic signed [7:0]     e_q;
    logic        [YW-1:0]  y_q;
    logic        [ITER-1:0] frac_q;
    logic        [CW-1:0]  cnt_q;
    logic signed [LW-1:0]  p_q;
    logic        [31:0]    q_q;
    logic                  err_q;
    logic                  done_q;
    logic                  busy_q;

    class_t                cls_d;
    logic        [YW-1:0]  y_init_d;
    logic        [YW-1:0]  ysq_d;
    logic signed [LW-1:0]  l_d;
    logic signed [LW-1:0]  p_d;
    logic        [31:0]    fp_d;

    // Signed Q8.ITER times unsigned Q0.32, truncated (floor) back to Q8.ITER
    function automatic logic signed [LW-1:0] scale_trunc(input logic signed [LW-1:0] l,
                                                         input logic [31:0] k);
        logic signed [LW+32:0] a;
        logic signed [LW+32:0] b;
        logic signed [LW+32:0] pr;
        a  = (LW+33)'(l);
        b  = $signed({{LW{1'b0}}, k});
        pr = a * b;
        return LW'(pr >>> 32);
    endfunction

    // Operand classification, initial mantissa, squaring step and base scaling
    always_comb begin
        cls_d    = classify(Mode_95, Op_X_95);
        y_init_d = YW'({2'b01, Op_X_95[22:0]}) << (YW - 25);
        ysq_d    = YW'(({{YW{1'b0}}, y_q} * {{YW{1'b0}}, y_q}) >> (YW - 2));
        l_d      = {e_q, frac_q};
        case (mode_q)
            MODE_LN:    p_d = scale_trunc(l_d, K_LN2);
            MODE_LOG10: p_d = scale_trunc(l_d, K_LOG10_2);
            default:    p_d = l_d;
        endcase
    end

    log_fix_to_fp #(
        .ITER(ITER)
    ) u_fix_to_fp (
        .fix_i(p_q),
        .fp_o (fp_d)
    );

    // Control FSM with registered result, error, done and busy outputs
    always_ff @(posedge clk_95 or posedge reset_95) begin
        if (reset_95) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            e_q     <= '0;
            y_q     <= '0;
            frac_q  <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
            q_q     <= '0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (Enable_95) begin
                        mode_q <= Mode_95;
                        busy_q <= 1'b1;
                        if (cls_d.special) begin
                            q_q     <= cls_d.q;
                            err_q   <= cls_d.err;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            e_q     <= 8'(int'(Op_X_95[30:23]) - EXP_BIAS);
                            y_q     <= y_init_d;
                            frac_q  <= '0;
                            cnt_q   <= '0;
                            state_q <= ST_ITER;
                        end
                    end
                end
                ST_ITER: begin
                    if (ysq_d[YW-1]) begin
                        frac_q <= {frac_q[ITER-2:0], 1'b1};
                        y_q    <= ysq_d >> 1;
                    end else begin
                        frac_q <= {frac_q[ITER-2:0], 1'b0};
                        y_q    <= ysq_d;
                    end
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(ITER - 1)) begin
                        state_q <= ST_SCALE;
                    end
                end
                ST_SCALE: begin
                    p_q     <= p_d;
                    state_q <= ST_NORM;
                end
                ST_NORM: begin
                    q_q     <= fp_d;
                    err_q   <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Op_Q_95  = q_q;
    assign Error_95 = err_q;
    assign Done_95  = done_q;
    assign Busy_95  = busy_q;

endmodule

// File: doc/log_unit_param.md
Name: log_unit_param

Overview:
- Parametrised, multi-cycle IEEE-754 single-precision logarithm unit. Successor to the fixed natural-log block.
- Adds a runtime base select (log2, ln, log10), a parametrised iteration count, a Busy handshake and full special-case classification.
- Sits on the datapath between operand registers and the result bus.
- Driven by a one-cycle Enable pulse; reports completion through a one-cycle Done pulse.

Parameters:
- ITER, 24: number of fraction bits of log2(mantissa) computed, one per cycle. Legal range 8..28.
- YW, 32: width of the squaring register, in Q2.(YW-2) format.

Ports:
- clk_95  in  1  clock; all state updates on the rising edge.
- reset_95  in  1  asynchronous, active-high reset.
- Enable_95  in  1  start request; sampled only in IDLE.
- Mode_95  in  2  base select: 00 log2, 01 ln, 10 log10, 11 reserved.
- Op_X_95  in  32  float32 operand.
- Op_Q_95  out  32  float32 result; held until the next accepted start.
- Error_95  out  1  operand or mode invalid; valid with Done, held with Op_Q.
- Done_95  out  1  one-cycle pulse when the result is valid.
- Busy_95  out  1  high from the cycle after acceptance until the cycle after the Done pulse.

Behaviour:
- Reset: state = IDLE; Op_Q_95 = 0, Error_95 = 0, Done_95 = 0, Busy_95 = 0; all internal registers cleared.
- Reset asserted mid-operation aborts the operation immediately. No Done pulse is produced.
- States: IDLE, ITER, SCALE, NORM, DONE.
- IDLE:
  - On an edge with Enable_95 = 1, capture Op_X_95 and Mode_95, then classify.
  - Special operand or reserved mode: load Op_Q/Error, go to DONE.
  - Otherwise: set e = exp - 127, set y = 1.mantissa in Q2.(YW-2), clear the fraction accumulator and counter, go to ITER.
- Special cases (Mode = 11 is checked first):
  - Mode 11 -> Q = 7FC00000, Err = 1.
  - NaN -> 7FC00000, Err = 1.
  - Sign = 1 and nonzero -> 7FC00000, Err = 1.
  - +0, -0 or subnormal -> FF800000, Err = 1.
  - +inf -> 7F800000, Err = 0.
- ITER, one cycle per bit, ITER cycles in total:
  - y <= y*y, truncated to Q2.(YW-2).
  - If the squared y >= 2: shift bit 1 into the fraction accumulator and y <= y/2. Else shift bit 0.
  - Counter reaching ITER-1 -> SCALE.
- SCALE, 1 cycle:
  - Form L = {e, frac} as a signed Q8.ITER value.
  - Mode 00: P = L (bypass, so powers of two are exact).
  - Mode 01: P = L * K_LN2.
  - Mode 10: P = L * K_LOG10_2.
  - The product is truncated back to Q8.ITER.
- NORM, 1 cycle:
  - Convert P to float32: sign from P, |P|, leading-one detect, exponent 127 + position, mantissa truncated to 23 bits.
  - P = 0 -> 00000000.
  - Error = 0. Go to DONE.
- DONE:
  - Done_95 = 1 for exactly one cycle. Op_Q and Error remain registered and stable. Return to IDLE.
  - Busy_95 drops in the IDLE cycle that follows.
- Latency, measured from the accepting edge to the cycle Done is high:
  - Special operands: 1 cycle.
  - Normal operands: ITER + 3 cycles (27 at default).
- Enable_95 is ignored outside IDLE. A held Enable restarts on the first IDLE edge after DONE, giving back-to-back operation.
- Operand and mode changes during Busy have no effect on the result.
- Accuracy: absolute error <= 2^-(ITER-2) against the ideal result for all normal operands. Exact for powers of two in log2 mode.

Decomposition:
- Shared package log_unit_pkg holds:
  - state enum
  - mode codes
  - K_LN2 = 0xB17217F8 and K_LOG10_2 = 0x4D104D42 (Q0.32)
  - float constants QNAN, NEG_INF and POS_INF
  - bias 127
- One sub-module: log_fix_to_fp. It is the combinational signed Q8.ITER to float32 converter (LOD plus shift) used by NORM, and can be unit-tested alone.

Test Plan:
- Mode 00, X = 3F800000 (1.0), Enable for one cycle -> Q = 00000000, Err = 0, Done exactly 27 cycles after acceptance, Busy high throughout.
- Mode 00, X = 41000000 (8.0) -> Q = 40400000. Then X = 3E800000 (0.25) -> Q = C0000000. Both exact.
- Mode 01, X = 40000000 (2.0) -> Q within 2^-22 absolute of 0.693147. Mode 10, X = 447A0000 (1000) -> Q within tolerance of 3.0 (40400000 or 403FFFFx).
- Specials, each with Done after 1 cycle:
  - X = BF800000 -> 7FC00000, Err = 1.
  - X = 00000000 -> FF800000, Err = 1.
  - X = 7F800000 -> 7F800000, Err = 0.
  - X = 7FC00001 -> 7FC00000, Err = 1.
  - Mode 11 with X = 3F800000 -> 7FC00000, Err = 1.
- Robustness:
  - Enable pulsed and Op_X changed at cycle 5 of an operation -> ignored, original result returned.
  - reset_95 asserted at cycle 10, asynchronous to the clock -> outputs zero immediately, no Done.
  - New op after reset -> correct.
- Random sweep of 10k normal operands across all modes -> compared to a real-valued model within tolerance. Held Enable -> back-to-back Done pulses every ITER+4 cycles.
